// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared widths, stream constants and state encoding for the loader
package instr_mem_loader_pkg;

  localparam int XLEN           = 32;
  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;
`endif

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] base,
                                                input logic [XLEN-1:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream handshake plus instruction memory write port
interface instr_mem_loader_if;
  import instr_mem_loader_pkg::*;

  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// rtl/instr_mem_loader_byte_assembler.sv - packs four stream bytes into a little-endian word
module instr_mem_loader_byte_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            byte_strobe,
  input  logic [7:0]      data_byte,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);

  logic [1:0]      index;
  logic [XLEN-9:0] shreg;

  // The three earlier bytes are held oldest-lowest so the 4th byte completes the word
  // combinationally, letting the caller register the memory write on the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index <= 2'd0;
      shreg <= '0;
    end else if (clear) begin
      index <= 2'd0;
      shreg <= '0;
    end else if (byte_strobe) begin
      index <= index + 2'd1;
      shreg <= {data_byte, shreg[XLEN-9:8]};
    end
  end

  assign word       = {data_byte, shreg};
  assign word_valid = byte_strobe && !clear && (index == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - fills instruction memory from a byte stream and holds the core until done; option LOADER_CHECKSUM_EN
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int              MEM_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  localparam int             WL_W      = $clog2(MEM_WORDS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                core_hold,
  output logic                done,
  output logic                error,
  output logic [WL_W-1:0]     words_loaded
);

  state_t          state;
  logic [WL_W-1:0] n_words;
  logic            last_pending;
  logic            accept;
  logic            restartable;
  logic            asm_strobe;
  logic [XLEN-1:0] asm_word;
  logic            asm_word_valid;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign accept      = bus.in_valid && bus.in_ready;
  assign restartable = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign asm_strobe  = accept && ((state == ST_HDR) || (state == ST_DATA));

  instr_mem_loader_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (start && restartable),
    .byte_strobe (asm_strobe),
    .data_byte   (bus.in_data),
    .word        (asm_word),
    .word_valid  (asm_word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      core_hold     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
      n_words       <= '0;
      last_pending  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_HDR;
            bus.in_ready <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            last_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= 8'h00;
`endif
          end
        end

        ST_HDR: begin
          if (asm_word_valid) begin
            if (asm_word == '0) begin
              n_words <= '0;
`ifdef LOADER_CHECKSUM_EN
              state   <= ST_CSUM;
`else
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              core_hold    <= 1'b0;
`endif
            end else if (asm_word > XLEN'(MEM_WORDS)) begin
              state        <= ST_ERR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              state   <= ST_DATA;
              n_words <= asm_word[WL_W-1:0];
            end
          end
        end

        ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) begin
            csum <= csum ^ bus.in_data;
          end
`endif
          if (asm_word_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= word_addr(BASE_ADDR, XLEN'(words_loaded));
            bus.mem_wdata <= asm_word;
            words_loaded  <= words_loaded + 1'b1;
            // Stop taking bytes as soon as the final word is complete; the
            // state change waits for the write cycle itself.
            if (words_loaded + 1'b1 == n_words) begin
              last_pending <= 1'b1;
              bus.in_ready <= 1'b0;
            end
          end
          if (last_pending) begin
            last_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            state        <= ST_CSUM;
            bus.in_ready <= 1'b1;
`else
            state        <= ST_DONE;
            done         <= 1'b1;
            core_hold    <= 1'b0;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state        <= ST_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory. The core only reads instruction memory; this block fills it before the core runs.
- Takes a byte stream over a valid/ready handshake (e.g. from a UART or debug link) and assembles little-endian XLEN-bit words.
- Writes each word into the instruction-memory write port.
- Holds the core in reset until the program load finishes.

Parameters:
- XLEN, 32, data/address width; only 32 is supported, so 4 bytes per word.
- MEM_WORDS, 1024, instruction memory capacity in words.
- BASE_ADDR, 0, byte address of word 0; must be a multiple of 4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  XLEN  byte address of the write
- mem_wdata  output  XLEN  word to write
- core_hold  output  1  high keeps the core in reset
- done  output  1  load completed successfully; sticky
- error  output  1  load aborted; sticky
- words_loaded  output  clog2(MEM_WORDS)+1  count of words written

Behaviour:
- Reset (rst=0, asynchronous, takes effect at any point including mid-load):
  - State goes to IDLE.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, done=0, error=0, words_loaded=0.
- All outputs are registered.
- Handshake: a byte transfers when in_valid && in_ready. in_data is sampled on that edge. Upstream must hold in_data stable while in_valid=1 && in_ready=0.
- Stream format:
  - 4-byte header N, little-endian: the word count.
  - Then 4*N data bytes, each word little-endian (first byte is bits [7:0]).
  - With LOADER_CHECKSUM_EN, one trailing checksum byte.
- States:
  - IDLE: in_ready=0. start moves to HDR.
  - HDR: in_ready=1. After the 4th byte accepted:
    - N=0 goes to DONE.
    - N>MEM_WORDS goes to ERR.
    - Otherwise goes to DATA.
  - DATA: in_ready=1. On each 4th byte accepted:
    - The next cycle drives mem_we=1, mem_addr=BASE_ADDR+4*words_loaded (pre-increment), mem_wdata=the assembled word.
    - words_loaded increments in that same cycle.
    - The byte stream is not stalled by the write.
    - After the write of word N: goes to CSUM (feature on) or DONE (feature off). The transition occurs in the cycle after that write pulse.
  - DONE: done=1, core_hold=0, in_ready=0.
  - ERR: error=1, core_hold=1, in_ready=0.
- start is honoured only in IDLE, DONE and ERR. Leaving DONE or ERR on start:
  - clears done, error and words_loaded;
  - sets core_hold=1;
  - goes to HDR.
- start is ignored in HDR, DATA and CSUM.
- Bytes offered in IDLE, DONE or ERR are not accepted, because in_ready=0.
- mem_we is never asserted outside DATA write cycles. The highest address written is BASE_ADDR+4*(MEM_WORDS-1).
- Latency: the last data byte is accepted at cycle t. mem_we occurs at t+1. done=1 and core_hold=0 appear at t+2 (feature off).

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of all data bytes is kept; header bytes are excluded.
  - CSUM state takes one byte with in_ready=1.
  - Match goes to DONE; mismatch goes to ERR.
  - Words already written stay in memory.
  - For N=0, CSUM is still entered and the expected value is 0x00.
- Disabled: no CSUM state and no XOR register. After the last write the FSM goes straight to DONE.

Decomposition:
- Shared header, Parameters.vh: XLEN, loader state encodings (IDLE, HDR, DATA, CSUM, DONE, ERR), HDR_BYTES=4, BYTES_PER_WORD=4.
- Sub-module byte_assembler:
  - 2-bit byte index and shift register.
  - Inputs: byte strobe and clear.
  - Outputs: word and a word_valid pulse.
  - Used for both header and data words.

Test Plan:
- Reset then start; header 02 00 00 00; data 13 00 00 00, 93 00 10 00 -> mem_we at 0x0 (data 0x00000013) and at 0x4 (data 0x00100093); done=1, core_hold=0, words_loaded=2.
- Header 00 00 00 00 -> DONE directly with no mem_we (feature off). With feature on, checksum byte 00 -> DONE.
- Header with N=MEM_WORDS+1 (0x401) -> error=1, core_hold=1, no mem_we, in_ready=0.
- in_valid toggled randomly during the 2-word load -> same writes and order as the first scenario. Also pulse start mid-DATA -> ignored.
- rst=0 asserted after 5 data bytes -> immediate reset values. Then start plus a full 1-word stream -> write at 0x0 only.
- Feature on, 1 word AA BB CC DD, checksum byte 00 -> DONE. Same stream with checksum 01 -> ERR after the word is written.
